// File: rtl/y_signature_checker.sv
// Compares a golden and a netlist output bus sample by sample, logging the
// first mismatch, counting mismatches and compressing y_dut into a 32-bit MISR.
module y_signature_checker #(
  parameter int          WIDTH = 754,
  parameter int          NSAMP = 20,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'h00000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] y_ref,
  input  logic [WIDTH-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mismatch_count,
  output logic [15:0]      first_mismatch_idx,
  output logic [9:0]       first_mismatch_bit,
  output logic [31:0]      signature
);

  localparam int NWORDS = (WIDTH + 31) / 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic                  busy_d;
  logic                  done_d;
  logic [15:0]           sample_idx;
  logic                  start_ok;
  logic                  accept;
  logic                  last_sample;
  logic                  mism;
  logic [WIDTH-1:0]      diff;
  logic [9:0]            low_bit;
  logic [NWORDS*32-1:0]  y_ext;
  logic [31:0]           fold;
  logic [31:0]           sig_next;

  assign start_ok    = start && (state != RUN);
  assign accept      = (state == RUN) && valid;
  assign last_sample = accept && (sample_idx == 16'(NSAMP - 1));
  assign diff        = y_ref ^ y_dut;
  assign mism        = |diff;

  // Scanning from the top down leaves the lowest differing bit as the winner.
  always_comb begin
    low_bit = 10'h3FF;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) low_bit = 10'(i);
    end
  end

  always_comb begin
    y_ext = '0;
    y_ext[WIDTH-1:0] = y_dut;
    fold = 32'h0;
    for (int w = 0; w < NWORDS; w++) begin
      fold = fold ^ y_ext[w*32 +: 32];
    end
    sig_next = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)       next_state = RUN;
      RUN:     if (last_sample) next_state = DONE;
      DONE:    if (start)       next_state = RUN;
      default:                  next_state = IDLE;
    endcase
  end

  // Status flags are decoded from the upcoming state so they toggle on the
  // same edge as the state itself and stay registered outputs.
  always_comb begin
    busy_d = (next_state == RUN);
    done_d = (next_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_idx         <= 16'h0;
      mismatch_count     <= 16'h0;
      first_mismatch_idx <= 16'hFFFF;
      first_mismatch_bit <= 10'h3FF;
      signature          <= SEED;
      pass               <= 1'b0;
    end else if (start_ok) begin
      sample_idx         <= 16'h0;
      mismatch_count     <= 16'h0;
      first_mismatch_idx <= 16'hFFFF;
      first_mismatch_bit <= 10'h3FF;
      signature          <= SEED;
      pass               <= 1'b0;
    end else if (accept) begin
      sample_idx <= sample_idx + 16'd1;
      signature  <= sig_next;
      if (mism) begin
        if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
        if (first_mismatch_idx == 16'hFFFF) begin
          first_mismatch_idx <= sample_idx;
          first_mismatch_bit <= low_bit;
        end
      end
      // The final sample's own mismatch must count against the verdict.
      if (last_sample) pass <= (mismatch_count == 16'h0) && !mism;
    end
  end

endmodule

// File: tb/tb_y_signature_checker.sv
// Self-checking bench for y_signature_checker: directed vector table, directed
// corner sequences, randomized runs against a sample-list model, and a saturation run.
module tb_y_signature_checker;

  localparam int W = 754;

  logic          clk = 1'b0;
  logic          rst_n, start, valid;
  logic [W-1:0]  y_ref, y_dut;
  logic          busy, done, pass;
  logic [15:0]   mismatch_count, first_mismatch_idx;
  logic [9:0]    first_mismatch_bit;
  logic [31:0]   signature;

  logic          rst_n_big, start_big, valid_big;
  logic [W-1:0]  y_ref_big, y_dut_big;
  logic          busy_big, done_big, pass_big;
  logic [15:0]   count_big, idx_big;
  logic [9:0]    bit_big;
  logic [31:0]   sig_big;
  logic          big_finished = 1'b0;

  int check_count = 0;
  int pass_count  = 0;

  logic [W-1:0] ref_q[$];
  logic [W-1:0] dut_q[$];
  logic [15:0]  exp_cnt, exp_idx;
  logic [9:0]   exp_bit;
  logic [31:0]  exp_sig;
  logic         exp_pass;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] d;
    logic [31:0]  sig;
    logic [15:0]  cnt;
    logic [9:0]   bitx;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  y_signature_checker #(.WIDTH(W), .NSAMP(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
    .y_ref(y_ref), .y_dut(y_dut), .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mismatch_count), .first_mismatch_idx(first_mismatch_idx),
    .first_mismatch_bit(first_mismatch_bit), .signature(signature)
  );

  y_signature_checker #(.WIDTH(W), .NSAMP(65535)) dut_big (
    .clk(clk), .rst_n(rst_n_big), .start(start_big), .valid(valid_big),
    .y_ref(y_ref_big), .y_dut(y_dut_big), .busy(busy_big), .done(done_big),
    .pass(pass_big), .mismatch_count(count_big), .first_mismatch_idx(idx_big),
    .first_mismatch_bit(bit_big), .signature(sig_big)
  );

  function automatic logic [W-1:0] one_hot(input int b);
    logic [W-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [767:0] t;
    for (int i = 0; i < 24; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  // Reference: XOR of the 24 zero-extended 32-bit words, then a Galois MISR step.
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [W-1:0] y);
    logic [767:0] e;
    logic [31:0]  f;
    e = '0;
    e[W-1:0] = y;
    f = 32'h0;
    for (int w = 0; w < 24; w++) f = f ^ e[w*32 +: 32];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [9:0] lowest(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) if (d[i]) return 10'(i);
    return 10'h3FF;
  endfunction

  task automatic compute_expected();
    int n_mm;
    n_mm     = 0;
    exp_idx  = 16'hFFFF;
    exp_bit  = 10'h3FF;
    exp_sig  = 32'h0;
    for (int i = 0; i < ref_q.size(); i++) begin
      if (ref_q[i] != dut_q[i]) begin
        n_mm++;
        if (exp_idx == 16'hFFFF) begin
          exp_idx = 16'(i);
          exp_bit = lowest(ref_q[i] ^ dut_q[i]);
        end
      end
      exp_sig = misr_step(exp_sig, dut_q[i]);
    end
    exp_cnt  = (n_mm > 65535) ? 16'hFFFF : 16'(n_mm);
    exp_pass = (n_mm == 0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'h0);
    checkOutput({tag, "_count"}, 32'(mismatch_count), 32'h0);
    checkOutput({tag, "_idx"}, 32'(first_mismatch_idx), 32'hFFFF);
    checkOutput({tag, "_bit"}, 32'(first_mismatch_bit), 32'h3FF);
    checkOutput({tag, "_sig"}, signature, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; y_ref = '0; y_dut = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // A valid mismatching sample rides along with start and must not be accepted.
  task automatic start_run();
    @(negedge clk);
    start = 1'b1; valid = 1'b1; y_ref = '0; y_dut = one_hot(3);
    @(negedge clk);
    start = 1'b0; valid = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'h1);
    checkOutput("done_after_start", 32'(done), 32'h0);
    checkOutput("count_after_start", 32'(mismatch_count), 32'h0);
    checkOutput("sig_after_start", signature, 32'h0);
  endtask

  task automatic applyStimulus(input int from, input bit gaps, input bit restart_noise);
    for (int i = from; i < ref_q.size(); i++) begin
      if (gaps) begin
        valid = 1'b0; y_ref = rand_vec(); y_dut = rand_vec(); start = restart_noise;
        @(negedge clk);
      end
      if (i == ref_q.size() - 1) checkOutput("done_before_last", 32'(done), 32'h0);
      valid = 1'b1; y_ref = ref_q[i]; y_dut = dut_q[i];
      start = restart_noise ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
    end
    valid = 1'b0; start = 1'b0;
  endtask

  task automatic finish_check(input string tag);
    compute_expected();
    checkOutput({tag, "_done"}, 32'(done), 32'h1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_count"}, 32'(mismatch_count), 32'(exp_cnt));
    checkOutput({tag, "_idx"}, 32'(first_mismatch_idx), 32'(exp_idx));
    checkOutput({tag, "_bit"}, 32'(first_mismatch_bit), 32'(exp_bit));
    checkOutput({tag, "_sig"}, signature, exp_sig);
    checkOutput({tag, "_pass"}, 32'(pass), 32'(exp_pass));
  endtask

  task automatic gen_random(input int n, input int mm_pct);
    logic [W-1:0] r, d;
    ref_q.delete(); dut_q.delete();
    for (int i = 0; i < n; i++) begin
      r = rand_vec(); d = r;
      if ($urandom_range(99) < mm_pct) begin
        d[$urandom_range(W-1)] ^= 1'b1;
        if ($urandom_range(1) == 1) d[$urandom_range(W-1)] ^= 1'b1;
      end
      ref_q.push_back(r); dut_q.push_back(d);
    end
  endtask

  task automatic zero_queue(input int n);
    ref_q.delete(); dut_q.delete();
    for (int i = 0; i < n; i++) begin
      ref_q.push_back('0); dut_q.push_back('0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; y_ref = '0; y_dut = '0;
    vecs[0] = '{r: one_hot(0),   d: one_hot(0),                sig: 32'h00000001, cnt: 16'd0, bitx: 10'h3FF};
    vecs[1] = '{r: one_hot(753), d: one_hot(753),              sig: 32'h00020000, cnt: 16'd0, bitx: 10'h3FF};
    vecs[2] = '{r: '0,           d: one_hot(700) | one_hot(12), sig: 32'h10001000, cnt: 16'd1, bitx: 10'd12};
    vecs[3] = '{r: '0,           d: one_hot(0) | one_hot(32),  sig: 32'h00000000, cnt: 16'd1, bitx: 10'd0};
    vecs[4] = '{r: '1,           d: '1,                        sig: 32'hFFFC0000, cnt: 16'd0, bitx: 10'h3FF};
    vecs[5] = '{r: one_hot(753), d: '0,                        sig: 32'h00000000, cnt: 16'd1, bitx: 10'h2F1};

    #12;
    check_reset_values("init");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-sample fold and compare vectors, each from a fresh reset.
    for (int k = 0; k < 6; k++) begin
      do_reset();
      start_run();
      valid = 1'b1; y_ref = vecs[k].r; y_dut = vecs[k].d;
      @(negedge clk);
      valid = 1'b0;
      checkOutput($sformatf("vec%0d_sig", k), signature, vecs[k].sig);
      checkOutput($sformatf("vec%0d_count", k), 32'(mismatch_count), 32'(vecs[k].cnt));
      checkOutput($sformatf("vec%0d_bit", k), 32'(first_mismatch_bit), 32'(vecs[k].bitx));
      checkOutput($sformatf("vec%0d_busy", k), 32'(busy), 32'h1);
    end

    // All-zero run.
    do_reset();
    zero_queue(20);
    start_run();
    applyStimulus(0, 1'b0, 1'b0);
    finish_check("zero_run");
    checkOutput("zero_run_pass_const", 32'(pass), 32'h1);

    // Signature shift: restart from DONE.
    zero_queue(20);
    ref_q[0] = one_hot(0); dut_q[0] = one_hot(0);
    start_run();
    valid = 1'b1; y_ref = ref_q[0]; y_dut = dut_q[0];
    @(negedge clk);
    checkOutput("shift_sig1", signature, 32'h00000001);
    y_ref = ref_q[1]; y_dut = dut_q[1];
    @(negedge clk);
    valid = 1'b0;
    checkOutput("shift_sig2", signature, 32'h00000002);
    applyStimulus(2, 1'b0, 1'b0);
    finish_check("shift_run");

    // Mismatch at sample 5 in bits 700 and 12, then ignored valid traffic in DONE.
    gen_random(20, 0);
    dut_q[5] = ref_q[5] ^ one_hot(700) ^ one_hot(12);
    start_run();
    applyStimulus(0, 1'b0, 1'b0);
    finish_check("s5_run");
    checkOutput("s5_count_const", 32'(mismatch_count), 32'd1);
    checkOutput("s5_idx_const", 32'(first_mismatch_idx), 32'd5);
    checkOutput("s5_bit_const", 32'(first_mismatch_bit), 32'd12);
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; y_ref = '0; y_dut = rand_vec() | one_hot(1);
      @(negedge clk);
    end
    valid = 1'b0;
    checkOutput("s5_hold_count", 32'(mismatch_count), 32'd1);
    checkOutput("s5_hold_sig", signature, exp_sig);
    checkOutput("s5_hold_done", 32'(done), 32'h1);

    // Alternate-cycle valid with start noise during RUN.
    gen_random(20, 30);
    start_run();
    applyStimulus(0, 1'b1, 1'b1);
    finish_check("alt_run");

    // Reset after 7 samples with 2 mismatches, then a fresh run.
    gen_random(7, 0);
    dut_q[1] = ref_q[1] ^ one_hot(400);
    dut_q[4] = ref_q[4] ^ one_hot(9);
    start_run();
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("pre_abort_count", 32'(mismatch_count), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
    gen_random(20, 0);
    dut_q[9] = ref_q[9] ^ one_hot(77);
    start_run();
    applyStimulus(0, 1'b0, 1'b0);
    finish_check("fresh_run");

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      gen_random(20, 25);
      start_run();
      applyStimulus(0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      finish_check($sformatf("rand%0d", r));
    end

    begin
      int waited;
      waited = 0;
      while (!big_finished && waited < 80000) begin
        @(negedge clk);
        waited++;
      end
      if (!big_finished) checkOutput("big_wait_timeout", 32'h0, 32'h1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Saturation run on a second instance, concurrent with the directed tests.
  initial begin
    logic [31:0] s;
    int cycles;
    rst_n_big = 1'b0; start_big = 1'b0; valid_big = 1'b0;
    y_ref_big = '0; y_dut_big = one_hot(0);
    repeat (2) @(negedge clk);
    rst_n_big = 1'b1;
    @(negedge clk);
    start_big = 1'b1;
    @(negedge clk);
    start_big = 1'b0; valid_big = 1'b1;
    cycles = 0;
    while (!done_big && cycles < 70000) begin
      @(negedge clk);
      cycles++;
    end
    valid_big = 1'b0;
    s = 32'h0;
    for (int i = 0; i < 65535; i++) s = misr_step(s, one_hot(0));
    checkOutput("big_done", 32'(done_big), 32'h1);
    checkOutput("big_count", 32'(count_big), 32'hFFFF);
    checkOutput("big_idx", 32'(idx_big), 32'h0);
    checkOutput("big_bit", 32'(bit_big), 32'h0);
    checkOutput("big_pass", 32'(pass_big), 32'h0);
    checkOutput("big_sig", sig_big, s);
    big_finished = 1'b1;
  end

endmodule
